// File: rtl/uart_rx.sv
// 8N1 serial receiver: double-flop input sync, mid-bit sampling FSM and a
// single-entry output buffer with valid/ready handshake, frame-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bitn_q, bitn_d;
    logic [7:0]     sh_q, sh_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           rx_meta_q, rx_s_q;
    logic           byteDone;

    // Both sync flops reset high so the idle line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitn_d   = bitn_q;
        sh_d     = sh_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        byteDone = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d  = '0;
                    bitn_d = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    cnt_d = '0;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d  = IDLE;
                        byteDone = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing byte may load only if the buffer is empty or being drained this cycle.
        if (byteDone) begin
            if (!valid_q || rx_ready) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// sequences for timing, back-to-back, glitch, break, overrun and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expBytes;
        int         expFerr;
    } vec_t;

    vec_t vecs[6];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Observation counters, owned by the monitor; tests compare deltas against snapshots.
    int         validRises = 0;
    int         lastRiseCyc = 0;
    int         validRun = 0;
    int         longRuns = 0;
    int         frameErrCnt = 0;
    int         overrunCnt = 0;
    int         busyCycles = 0;
    logic       prevValid = 1'b0;
    logic [7:0] gotQ[$];

    int bRises, bLong, bFerr, bOvr, bBusy, bGot, startCyc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rx_valid && !prevValid) begin
            validRises++;
            lastRiseCyc = cyc;
        end
        if (rx_valid) begin
            validRun++;
            if (validRun == 2) longRuns++;
        end else begin
            validRun = 0;
        end
        if (rx_valid && rx_ready) gotQ.push_back(rx_data);
        if (frame_err) frameErrCnt++;
        if (overrun) overrunCnt++;
        if (busy) busyCycles++;
        prevValid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic snap();
        bRises = validRises;
        bLong  = longRuns;
        bFerr  = frameErrCnt;
        bOvr   = overrunCnt;
        bBusy  = busyCycles;
        bGot   = gotQ.size();
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        tick(N);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
        sendBit(stopBit);
    endtask

    function automatic int gotAt(input int idx);
        if (idx < gotQ.size()) return int'(gotQ[idx]);
        return -1;
    endfunction

    initial begin
        vecs[0] = '{data: 8'hA5, stopBit: 1'b1, expBytes: 1, expFerr: 0};
        vecs[1] = '{data: 8'h5A, stopBit: 1'b1, expBytes: 1, expFerr: 0};
        vecs[2] = '{data: 8'h01, stopBit: 1'b1, expBytes: 1, expFerr: 0};
        vecs[3] = '{data: 8'h80, stopBit: 1'b1, expBytes: 1, expFerr: 0};
        vecs[4] = '{data: 8'hC3, stopBit: 1'b0, expBytes: 0, expFerr: 1};
        vecs[5] = '{data: 8'hFF, stopBit: 1'b0, expBytes: 0, expFerr: 1};

        // Reset and idle
        tick(3);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset busy", busy, 0);
        snap();
        rst_n = 1'b1;
        tick(100);
        checkOutput("idle rx_valid", rx_valid, 0);
        checkOutput("idle rx_data", rx_data, 0);
        checkOutput("idle busy cycles", busyCycles - bBusy, 0);
        checkOutput("idle frame_err", frameErrCnt - bFerr, 0);
        checkOutput("idle overrun", overrunCnt - bOvr, 0);

        // Table-driven single frames, consumer always ready
        rx_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            snap();
            applyStimulus(vecs[v].data, vecs[v].stopBit);
            rx = 1'b1;
            tick(2 * N);
            checkOutput($sformatf("vec%0d bytes", v), gotQ.size() - bGot, vecs[v].expBytes);
            checkOutput($sformatf("vec%0d frame_err", v), frameErrCnt - bFerr, vecs[v].expFerr);
            checkOutput($sformatf("vec%0d busy end", v), busy, 0);
            if (vecs[v].expBytes == 1)
                checkOutput($sformatf("vec%0d data", v), gotAt(bGot), int'(vecs[v].data));
        end

        // Single byte with latency check, consumer not ready
        rx_ready = 1'b0;
        snap();
        startCyc = cyc;
        applyStimulus(8'hA5, 1'b1);
        tick(20);
        checkOutput("single rises", validRises - bRises, 1);
        checkOutput("single latency", lastRiseCyc - startCyc, 155);
        checkOutput("single held valid", rx_valid, 1);
        checkOutput("single data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        tick(1);
        checkOutput("single cleared", rx_valid, 0);
        checkOutput("single accepted", gotAt(bGot), 8'hA5);

        // Back-to-back frames at full line rate
        snap();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        tick(2 * N);
        checkOutput("b2b count", gotQ.size() - bGot, 3);
        checkOutput("b2b byte0", gotAt(bGot), 8'h00);
        checkOutput("b2b byte1", gotAt(bGot + 1), 8'hFF);
        checkOutput("b2b byte2", gotAt(bGot + 2), 8'h3C);
        checkOutput("b2b rises", validRises - bRises, 3);
        checkOutput("b2b long pulses", longRuns - bLong, 0);
        checkOutput("b2b flags", (frameErrCnt - bFerr) + (overrunCnt - bOvr), 0);

        // Short glitch
        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * N);
        checkOutput("glitch busy seen", int'((busyCycles - bBusy) > 0), 1);
        checkOutput("glitch busy end", busy, 0);
        checkOutput("glitch rises", validRises - bRises, 0);
        checkOutput("glitch frame_err", frameErrCnt - bFerr, 0);

        // Framing error followed by a long break
        snap();
        applyStimulus(8'h55, 1'b0);
        rx = 1'b0;
        tick(40 * N);
        checkOutput("break frame_err", frameErrCnt - bFerr, 1);
        checkOutput("break rises", validRises - bRises, 0);
        checkOutput("break busy held", busy, 1);
        rx = 1'b1;
        tick(5);
        checkOutput("break busy end", busy, 0);

        // Overrun
        rx_ready = 1'b0;
        snap();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        tick(N);
        checkOutput("ovr pulses", overrunCnt - bOvr, 1);
        checkOutput("ovr data kept", rx_data, 8'h11);
        checkOutput("ovr valid", rx_valid, 1);
        rx_ready = 1'b1;
        tick(1);
        checkOutput("ovr accepted count", gotQ.size() - bGot, 1);
        checkOutput("ovr accepted data", gotAt(bGot), 8'h11);
        checkOutput("ovr cleared", rx_valid, 0);

        // Reset during bit 3 of 0x81, then a clean 0x42
        snap();
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        rx = 1'b0;
        tick(N / 2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset valid", rx_valid, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * N);
        applyStimulus(8'h42, 1'b1);
        tick(2 * N);
        checkOutput("mid reset count", gotQ.size() - bGot, 1);
        checkOutput("mid reset data", gotAt(bGot), 8'h42);
        checkOutput("mid reset flags", (frameErrCnt - bFerr) + (overrunCnt - bOvr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
